// File: rtl/pe_pkg.sv
// ----------------------------------------------------------------------------
// pe_pkg
//   Shared definitions for the priority encoder / priority decoder pair.
//   Holds the default vector and index widths so that both ends of an
//   encoder -> decoder chain agree, and the decoder FSM state type.
//
//   Contents:
//     PE_DATA_LEN    default width of the one-hot / raw data vector
//     PE_RESULT_LEN  default width of the encoded index ($clog2 of the above)
//     pd_state_t     decoder control states IDLE / LOAD / WALK / DONE
// ----------------------------------------------------------------------------
package pe_pkg;

    localparam int PE_DATA_LEN   = 20;
    localparam int PE_RESULT_LEN = $clog2(PE_DATA_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WALK = 2'd2,
        DONE = 2'd3
    } pd_state_t;

endpackage : pe_pkg

// File: rtl/pd_walker.sv
// ----------------------------------------------------------------------------
// pd_walker
//   Datapath of the priority decoder. A single set bit walks up a shift
//   register, one position per step, while a counter tracks its position.
//   hit_o tells the controlling FSM that the walking bit sits at the
//   requested index. With THERMO_MASK_EN defined, a thermometer mask is
//   grown in lock-step so that it covers bits [count:0].
//
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-low reset
//     load_i    in   restart the walk: walker=1, count=0 (mask=1)
//     step_i    in   advance the walk by one bit position
//     index_i   in   target bit position (compared against count)
//     walker_o  out  current one-hot walking vector
//     hit_o     out  count equals index_i
//     mask_o    out  thermometer mask [count:0]  (THERMO_MASK_EN only)
//
//   Configuration macro: THERMO_MASK_EN
// ----------------------------------------------------------------------------
module pd_walker
    import pe_pkg::*;
#(
    parameter int DATA_LEN   = PE_DATA_LEN,
    parameter int RESULT_LEN = PE_RESULT_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [RESULT_LEN-1:0] index_i,
    output logic [DATA_LEN-1:0]   walker_o,
`ifdef THERMO_MASK_EN
    output logic [DATA_LEN-1:0]   mask_o,
`endif
    output logic                  hit_o
);

    localparam logic [DATA_LEN-1:0] ONE_HOT_LSB = {{(DATA_LEN-1){1'b0}}, 1'b1};

    logic [DATA_LEN-1:0]   walker_q, walker_d;
    logic [RESULT_LEN-1:0] count_q,  count_d;
`ifdef THERMO_MASK_EN
    logic [DATA_LEN-1:0]   mask_q,   mask_d;
`endif

    // Load has priority over step so a fresh request always starts from bit 0.
    always_comb begin
        walker_d = walker_q;
        count_d  = count_q;
`ifdef THERMO_MASK_EN
        mask_d   = mask_q;
`endif
        if (load_i) begin
            walker_d = ONE_HOT_LSB;
            count_d  = '0;
`ifdef THERMO_MASK_EN
            mask_d   = ONE_HOT_LSB;
`endif
        end else if (step_i) begin
            walker_d = walker_q << 1;
            // The FSM stops stepping at index < DATA_LEN, so count never wraps.
            count_d  = count_q + 1'b1;
`ifdef THERMO_MASK_EN
            mask_d   = (mask_q << 1) | ONE_HOT_LSB;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            walker_q <= '0;
            count_q  <= '0;
`ifdef THERMO_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            walker_q <= walker_d;
            count_q  <= count_d;
`ifdef THERMO_MASK_EN
            mask_q   <= mask_d;
`endif
        end
    end

    assign walker_o = walker_q;
    assign hit_o    = (count_q == index_i);
`ifdef THERMO_MASK_EN
    assign mask_o   = mask_q;
`endif

endmodule : pd_walker

// File: rtl/priority_decoder.sv
// ----------------------------------------------------------------------------
// priority_decoder
//   Inverse of priority_encoder: rebuilds a one-hot DATA_LEN vector from an
//   encoded index plus zero flag. A request is accepted in IDLE, checked in
//   LOAD, the bit is walked into place in WALK, and DONE raises a one-cycle
//   completion pulse. Results are held until the next accepted request.
//
//   Latency from the accepting edge to dut_done: index+3 cycles for a valid
//   index, 2 cycles for zero_in=1 or an out-of-range index.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-low reset
//     dut_start  in   request, sampled only while dut_ready=1
//     dut_ready  out  idle, will accept dut_start
//     dut_done   out  one-cycle pulse, data_out / err_f valid
//     index_in   in   bit position to set (encoder result)
//     zero_in    in   encoder zero flag, forces an all-zero result
//     data_out   out  one-hot result
//     err_f      out  index_in >= DATA_LEN with zero_in=0
//     mask_out   out  thermometer mask [index:0] (THERMO_MASK_EN only)
//
//   Configuration macro: THERMO_MASK_EN adds mask_out and its register.
// ----------------------------------------------------------------------------
module priority_decoder
    import pe_pkg::*;
#(
    parameter int DATA_LEN   = PE_DATA_LEN,
    parameter int RESULT_LEN = PE_RESULT_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dut_start,
    output logic                  dut_ready,
    output logic                  dut_done,
    input  logic [RESULT_LEN-1:0] index_in,
    input  logic                  zero_in,
    output logic [DATA_LEN-1:0]   data_out,
`ifdef THERMO_MASK_EN
    output logic [DATA_LEN-1:0]   mask_out,
`endif
    output logic                  err_f
);

    pd_state_t             state_q, state_d;
    logic [RESULT_LEN-1:0] index_q, index_d;
    logic                  zero_q,  zero_d;
    logic [DATA_LEN-1:0]   data_q,  data_d;
    logic                  err_q,   err_d;
`ifdef THERMO_MASK_EN
    logic [DATA_LEN-1:0]   mask_q,  mask_d;
    logic [DATA_LEN-1:0]   walk_mask;
`endif

    logic                  walk_load;
    logic                  walk_step;
    logic                  walk_hit;
    logic [DATA_LEN-1:0]   walk_vec;
    logic                  index_oob;

    // Index widened to 32 bits so the range check also works when
    // RESULT_LEN can encode values at or beyond DATA_LEN.
    assign index_oob = ({{(32-RESULT_LEN){1'b0}}, index_q} >= 32'(DATA_LEN));

    pd_walker #(
        .DATA_LEN   (DATA_LEN),
        .RESULT_LEN (RESULT_LEN)
    ) u_walker (
        .clk      (clk),
        .rst      (rst),
        .load_i   (walk_load),
        .step_i   (walk_step),
        .index_i  (index_q),
        .walker_o (walk_vec),
`ifdef THERMO_MASK_EN
        .mask_o   (walk_mask),
`endif
        .hit_o    (walk_hit)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        zero_d    = zero_q;
        data_d    = data_q;
        err_d     = err_q;
`ifdef THERMO_MASK_EN
        mask_d    = mask_q;
`endif
        walk_load = 1'b0;
        walk_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (dut_start) begin
                    // Inputs are captured here only; later changes are ignored.
                    index_d = index_in;
                    zero_d  = zero_in;
                    data_d  = '0;
                    err_d   = 1'b0;
`ifdef THERMO_MASK_EN
                    mask_d  = '0;
`endif
                    state_d = LOAD;
                end
            end

            LOAD: begin
                if (zero_q) begin
                    state_d = DONE;
                end else if (index_oob) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    walk_load = 1'b1;
                    state_d   = WALK;
                end
            end

            WALK: begin
                if (walk_hit) begin
                    data_d  = walk_vec;
`ifdef THERMO_MASK_EN
                    mask_d  = walk_mask;
`endif
                    state_d = DONE;
                end else begin
                    walk_step = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            index_q <= '0;
            zero_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef THERMO_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            zero_q  <= zero_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef THERMO_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign dut_ready = (state_q == IDLE);
    assign dut_done  = (state_q == DONE);
    assign data_out  = data_q;
    assign err_f     = err_q;
`ifdef THERMO_MASK_EN
    assign mask_out  = mask_q;
`endif

endmodule : priority_decoder

// File: tb/tb_priority_decoder.sv
// ----------------------------------------------------------------------------
// tb_priority_decoder
//   Directed and randomized bench for priority_decoder (DATA_LEN=20,
//   RESULT_LEN=5). Expected results come from a behavioural model of the
//   decode rules; the round-trip section also models the upstream encoder.
//   Build with THERMO_MASK_EN defined to include the mask_out checks.
// ----------------------------------------------------------------------------
module tb_priority_decoder;

    localparam int DL = 20;
    localparam int RL = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          dut_start = 1'b0;
    logic          dut_ready;
    logic          dut_done;
    logic [RL-1:0] index_in = '0;
    logic          zero_in = 1'b0;
    logic [DL-1:0] data_out;
    logic          err_f;
`ifdef THERMO_MASK_EN
    logic [DL-1:0] mask_out;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    priority_decoder #(
        .DATA_LEN   (DL),
        .RESULT_LEN (RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dut_start (dut_start),
        .dut_ready (dut_ready),
        .dut_done  (dut_done),
        .index_in  (index_in),
        .zero_in   (zero_in),
        .data_out  (data_out),
`ifdef THERMO_MASK_EN
        .mask_out  (mask_out),
`endif
        .err_f     (err_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic bit ref_err(input int idx, input bit z);
        return !z && (idx >= DL);
    endfunction

    function automatic logic [31:0] ref_data(input int idx, input bit z);
        if (z || idx >= DL) return 32'd0;
        return 32'd1 << idx;
    endfunction

    function automatic logic [31:0] ref_mask(input int idx, input bit z);
        if (z || idx >= DL) return 32'd0;
        return (32'd1 << (idx + 1)) - 32'd1;
    endfunction

    function automatic int ref_lat(input int idx, input bit z);
        if (z || idx >= DL) return 2;
        return idx + 3;
    endfunction

    // Upstream encoder model: position of the highest set bit.
    function automatic int enc_index(input logic [DL-1:0] d);
        int pos = 0;
        for (int i = 0; i < DL; i++) if (d[i]) pos = i;
        return pos;
    endfunction

    // MSB isolation by smearing ones downward and keeping the top edge.
    function automatic logic [31:0] msb_isolate(input logic [DL-1:0] d);
        logic [31:0] x = 32'(d);
        x = x | (x >> 1);
        x = x | (x >> 2);
        x = x | (x >> 4);
        x = x | (x >> 8);
        x = x | (x >> 16);
        return x ^ (x >> 1);
    endfunction

    // Issue one request and wait for dut_done, counting edges from the
    // accepting edge. poke_at>0 pulses start with a different index at
    // that cycle to show the busy block ignores it.
    task automatic run_op(input string tag, input int idx, input bit z, input int poke_at);
        int lat;
        index_in  = RL'(idx);
        zero_in   = z;
        dut_start = 1'b1;
        @(posedge clk); #1;
        dut_start = 1'b0;
        lat = 1;
        while (dut_done !== 1'b1 && lat < 64) begin
            if (lat == poke_at) begin
                dut_start = 1'b1;
                index_in  = RL'(3);
                zero_in   = 1'b1;
            end else begin
                dut_start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        dut_start = 1'b0;
        check({tag, ":done"},    32'(dut_done),  32'd1);
        check({tag, ":latency"}, 32'(lat),       32'(ref_lat(idx, z)));
        check({tag, ":data"},    32'(data_out),  ref_data(idx, z));
        check({tag, ":err"},     32'(err_f),     32'(ref_err(idx, z)));
        check({tag, ":busy"},    32'(dut_ready), 32'd0);
`ifdef THERMO_MASK_EN
        check({tag, ":mask"},    32'(mask_out),  ref_mask(idx, z));
`endif
        @(posedge clk); #1;
        check({tag, ":pulse"},   32'(dut_done),  32'd0);
        check({tag, ":held"},    32'(data_out),  ref_data(idx, z));
        check({tag, ":ready"},   32'(dut_ready), 32'd1);
    endtask

    initial begin
        logic [DL-1:0] rnd;
        bit            done_seen;

        // 1. reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset:ready", 32'(dut_ready), 32'd1);
        check("reset:done",  32'(dut_done),  32'd0);
        check("reset:data",  32'(data_out),  32'd0);
        check("reset:err",   32'(err_f),     32'd0);
`ifdef THERMO_MASK_EN
        check("reset:mask",  32'(mask_out),  32'd0);
`endif

        // 2-5. directed decode cases
        run_op("idx12", 12, 1'b0, 0);
        run_op("idx0",  0,  1'b0, 0);
        run_op("idx19", 19, 1'b0, 0);
        run_op("zero7", 7,  1'b1, 0);
        run_op("err25", 25, 1'b0, 0);
        run_op("after_err", 5, 1'b0, 0);
        run_op("err20", 20, 1'b0, 0);

        // 6. start pulse and input change mid-walk are ignored
        run_op("ignore", 10, 1'b0, 4);

        // reset clears a held result
        run_op("pre_rst", 9, 1'b0, 0);
        rst = 1'b0; #1;
        check("rst_held:data", 32'(data_out), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // reset mid-walk: back to IDLE, no completion pulse
        index_in  = RL'(15);
        zero_in   = 1'b0;
        dut_start = 1'b1;
        @(posedge clk); #1 dut_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst:ready", 32'(dut_ready), 32'd1);
        check("midrst:done",  32'(dut_done),  32'd0);
        check("midrst:data",  32'(data_out),  32'd0);
        check("midrst:err",   32'(err_f),     32'd0);
        @(posedge clk); #1 rst = 1'b1;
        done_seen = 1'b0;
        repeat (24) begin
            @(posedge clk); #1;
            if (dut_done === 1'b1) done_seen = 1'b1;
        end
        check("midrst:no_done", 32'(done_seen), 32'd0);
        check("midrst:idle",    32'(dut_ready), 32'd1);

        // randomized requests, including out-of-range indices
        for (int n = 0; n < 24; n++) begin
            run_op("rand", int'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0), 0);
        end

        // round trip: encoder model -> decoder, compare with MSB isolation
        for (int n = 0; n < 16; n++) begin
            rnd = (n == 0) ? '0 : DL'($urandom) >> $urandom_range(0, DL - 1);
            index_in  = RL'(enc_index(rnd));
            zero_in   = (rnd == '0);
            dut_start = 1'b1;
            @(posedge clk); #1 dut_start = 1'b0;
            for (int c = 0; c < 40 && dut_done !== 1'b1; c++) begin
                @(posedge clk); #1;
            end
            check("roundtrip:done", 32'(dut_done), 32'd1);
            check("roundtrip:data", 32'(data_out), msb_isolate(rnd));
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_priority_decoder
